// File: rtl/wb_ram_responder.sv
// Wishbone classic responder in front of a word-wide synchronous RAM with byte-lane writes.
// Optional macro WB_RAM_ERR_EN adds o_wb_err for accesses outside the mapped window.
module wb_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack
`ifdef WB_RAM_ERR_EN
  ,
  output logic        o_wb_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdat_q;
  logic [3:0]     sel_q;
  logic           we_q;
  logic           bad_q;
  logic           ack_q;
  logic [31:0]    rdat_q;
  logic [31:0]    ram_q [DEPTH_WORDS];

  logic [AW-1:0]  in_idx;
  logic [AW-1:0]  rd_idx;
  logic           req_bad;
  logic           accept;
  logic           wait_done;
  logic           rd_en;
  logic           wr_en;

  // Window-relative word index; out-of-window addresses wrap onto the RAM.
  assign in_idx = AW'((i_wb_adr - BASE_ADDR) >> 2);

`ifdef WB_RAM_ERR_EN
  logic err_q;
  assign req_bad  = (((i_wb_adr - BASE_ADDR) >> (AW + 2)) != 32'd0);
  assign o_wb_err = err_q;
`else
  assign req_bad  = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && i_wb_cyc && i_wb_stb;
  assign wait_done = (state_q == ST_WAIT) && i_wb_cyc && (cnt_q == '0);

  // Read data is captured on the edge that enters ACK, so with zero wait
  // states the index comes straight from the bus rather than the latch.
  assign rd_idx = (state_q == ST_IDLE) ? in_idx : idx_q;
  assign rd_en  = (accept && (WAIT_STATES == 0) && !i_wb_we && !req_bad) ||
                  (wait_done && !we_q && !bad_q);
  assign wr_en  = (state_q == ST_ACK) && we_q && !bad_q && i_reset_n;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
`ifdef WB_RAM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef WB_RAM_ERR_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q  <= in_idx;
            wdat_q <= i_wb_dat;
            sel_q  <= i_wb_sel;
            we_q   <= i_wb_we;
            bad_q  <= req_bad;
            if (WAIT_STATES == 0) begin
              state_q <= ST_ACK;
              ack_q   <= !req_bad;
`ifdef WB_RAM_ERR_EN
              err_q   <= req_bad;
`endif
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!i_wb_cyc) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_ACK;
            ack_q   <= !bad_q;
`ifdef WB_RAM_ERR_EN
            err_q   <= bad_q;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) ram_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rdat_q <= '0;
    end else if (rd_en) begin
      rdat_q <= ram_q[rd_idx];
    end
  end

  assign o_wb_dat = rdat_q;
  assign o_wb_ack = ack_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: three instances (WAIT_STATES 1, 0, 3) driven from a vector table
// plus hand sequences for back-to-back, abort, reset-in-WAIT and out-of-window accesses.
module tb_wb_ram_responder;

  localparam int N = 3;
  localparam logic [N*8-1:0]  WS_P    = {8'd3, 8'd0, 8'd1};
  localparam logic [N*32-1:0] DEPTH_P = {32'd1024, 32'd64, 32'd1024};
  localparam logic [N*32-1:0] BASE_P  = {32'h0000_0000, 32'h0000_8000, 32'h0000_0000};

  logic          clk;
  logic [N-1:0]  rst_n;
  logic [31:0]   adr  [N];
  logic [31:0]   wdat [N];
  logic [3:0]    sel  [N];
  logic [31:0]   rdat [N];
  logic [N-1:0]  we, stb, cyc, ack, err;

  int n_checks = 0;
  int n_err    = 0;

  int          lat_r;
  logic [31:0] dat_r;
  logic        ack_r, err_r;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    wb_ram_responder #(
      .DEPTH_WORDS(int'(DEPTH_P[gi*32 +: 32])),
      .WAIT_STATES(int'(WS_P[gi*8 +: 8])),
      .BASE_ADDR  (BASE_P[gi*32 +: 32])
    ) u_dut (
      .i_clk    (clk),
      .i_reset_n(rst_n[gi]),
      .i_wb_adr (adr[gi]),
      .i_wb_dat (wdat[gi]),
      .i_wb_we  (we[gi]),
      .i_wb_sel (sel[gi]),
      .i_wb_stb (stb[gi]),
      .i_wb_cyc (cyc[gi]),
      .o_wb_dat (rdat[gi]),
      .o_wb_ack (ack[gi])
`ifdef WB_RAM_ERR_EN
      ,
      .o_wb_err (err[gi])
`endif
    );
  end

`ifndef WB_RAM_ERR_EN
  assign err = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One isolated transfer; inputs are scrambled after acceptance to prove the latch is used.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] v, input logic [3:0] s);
    @(negedge clk);
    adr[d] = a; wdat[d] = v; we[d] = w; sel[d] = s;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    @(negedge clk);
    stb[d] = 1'b0;
    adr[d] = ~a; wdat[d] = ~v; we[d] = ~w; sel[d] = ~s;
    lat_r = 1;
    while (!(ack[d] || err[d])) begin
      if (lat_r >= 20) break;
      @(negedge clk);
      lat_r++;
    end
    dat_r = rdat[d]; ack_r = ack[d]; err_r = err[d];
    cyc[d] = 1'b0;
    @(negedge clk);
    check($sformatf("d%0d_pulse_width", d), {31'b0, ack[d] | err[d]}, 32'd0);
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] v;
    logic [3:0]  s;
    logic [31:0] exp_dat;
    int          exp_lat;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int k;
    logic seen;

    tbl[0]  = '{0, 1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        2};
    tbl[1]  = '{0, 1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 2};
    tbl[2]  = '{0, 1'b1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF, 2};
    tbl[3]  = '{0, 1'b1, 32'h20,   32'h0000AA00, 4'h2, 32'hDEADBEEF, 2};
    tbl[4]  = '{0, 1'b0, 32'h20,   32'h0,        4'hF, 32'h1122AA44, 2};
    tbl[5]  = '{0, 1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h1122AA44, 2};
    tbl[6]  = '{0, 1'b0, 32'h23,   32'h0,        4'h0, 32'h1122AA44, 2};
    tbl[7]  = '{0, 1'b1, 32'h04,   32'h0BADF00D, 4'hF, 32'h1122AA44, 2};
    tbl[8]  = '{1, 1'b1, 32'h8000, 32'hA0A0A0A0, 4'hF, 32'h0,        1};
    tbl[9]  = '{1, 1'b1, 32'h8004, 32'hA1A1A1A1, 4'hF, 32'h0,        1};
    tbl[10] = '{1, 1'b1, 32'h8008, 32'hA2A2A2A2, 4'hF, 32'h0,        1};
    tbl[11] = '{1, 1'b1, 32'h800C, 32'hA3A3A3A3, 4'hF, 32'h0,        1};
    tbl[12] = '{2, 1'b1, 32'h40,   32'h01020304, 4'hF, 32'h0,        4};
    tbl[13] = '{2, 1'b1, 32'h80,   32'h55AA55AA, 4'hF, 32'h0,        4};
    tbl[14] = '{2, 1'b0, 32'h80,   32'h0,        4'hF, 32'h55AA55AA, 4};

    for (int d = 0; d < N; d++) begin
      adr[d] = '0; wdat[d] = '0; sel[d] = '0;
    end
    we = '0; stb = '0; cyc = '0; rst_n = '0;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d_reset_ack", d), {31'b0, ack[d]}, 32'd0);
      check($sformatf("d%0d_reset_dat", d), rdat[d], 32'd0);
    end

    for (int i = 0; i < 15; i++) begin
      xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].v, tbl[i].s);
      check($sformatf("v%0d_latency", i), lat_r, tbl[i].exp_lat);
      check($sformatf("v%0d_dat", i), dat_r, tbl[i].exp_dat);
`ifdef WB_RAM_ERR_EN
      check($sformatf("v%0d_err", i), {31'b0, err_r}, 32'd0);
`endif
    end

    // Out-of-window write to 0x1004 on the 1024-word instance.
    xfer(0, 1'b1, 32'h1004, 32'h77777777, 4'hF);
    check("oos_latency", lat_r, 2);
`ifdef WB_RAM_ERR_EN
    check("oos_err", {31'b0, err_r}, 32'd1);
    check("oos_ack", {31'b0, ack_r}, 32'd0);
    check("oos_dat_held", dat_r, 32'h1122AA44);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'hF);
    check("oos_word1", dat_r, 32'h0BADF00D);
`else
    check("oos_ack", {31'b0, ack_r}, 32'd1);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'hF);
    check("oos_word1", dat_r, 32'h77777777);
`endif

    // Back-to-back reads with stb/cyc held: ack every second cycle.
    @(negedge clk);
    adr[1] = 32'h8000; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack_c%0d", i), {31'b0, ack[1]}, {31'b0, (i % 2) == 0});
      if (ack[1]) begin
        check($sformatf("b2b_dat%0d", k), rdat[1], 32'hA0A0A0A0 + 32'h01010101 * k);
        k++;
        adr[1] = 32'h8000 + 32'(4 * k);
        if (k == 4) begin
          cyc[1] = 1'b0; stb[1] = 1'b0;
        end
      end
    end
    check("b2b_count", k, 4);

    // Abort: cyc dropped during WAIT of a write.
    @(negedge clk);
    adr[2] = 32'h40; wdat[2] = 32'hCAFEF00D; we[2] = 1'b1; sel[2] = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge clk);
    stb[2] = 1'b0;
    @(negedge clk);
    cyc[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack[2] | err[2];
    end
    check("abort_no_ack", {31'b0, seen}, 32'd0);
    xfer(2, 1'b0, 32'h40, 32'h0, 4'hF);
    check("abort_latency", lat_r, 4);
    check("abort_word", dat_r, 32'h01020304);

    // Reset during WAIT of a write.
    @(negedge clk);
    adr[2] = 32'h80; wdat[2] = 32'h12345678; we[2] = 1'b1; sel[2] = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge clk);
    stb[2] = 1'b0;
    rst_n[2] = 1'b0;
    @(negedge clk);
    check("rstw_ack", {31'b0, ack[2]}, 32'd0);
    check("rstw_dat", rdat[2], 32'd0);
    rst_n[2] = 1'b1;
    cyc[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= ack[2];
    end
    check("rstw_no_ack", {31'b0, seen}, 32'd0);
    xfer(2, 1'b0, 32'h80, 32'h0, 4'hF);
    check("rstw_latency", lat_r, 4);
    check("rstw_word", dat_r, 32'h55AA55AA);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
